// File: rtl/frame_pacer_ci.sv
// frame_pacer_ci: Nios II multi-cycle custom instruction that paces the game loop.
//
// A free-running frame timer counts 0..period-1 on every clk, whether or not clk_en
// is high. Each wrap raises an internal tick. Every tick increments a 32-bit frame
// counter and a saturating missed-frame (pending) counter.
//
// Opcodes (n), accepted only in IDLE while clk_en is high:
//   0 DELAY      : busy-wait dataa[CNT_W-1:0] enabled cycles, or one period if that
//                  field is 0. Latency from start to done is target+1. Result is 0.
//   1 SET_PERIOD : period = max(dataa[CNT_W-1:0], 2). Restarts the timer, clears
//                  pending and returns the old period.
//   2 WAIT_FRAME : returns pending at once if it is non-zero and clears it. Otherwise
//                  waits for the next tick, consumes that tick and returns 0.
//   3 READ_COUNT : returns frame_count. datab[0]=1 also clears the counter.
//
// Ports:
//   clk, reset    system clock; asynchronous active-high reset
//   clk_en        custom-instruction clock enable; low freezes the instruction FSM
//   start         one-cycle instruction start
//   n             opcode
//   dataa, datab  operands
//   result        registered result; holds until the next completion
//   done          one-cycle completion pulse
//
// Optional build: define FRAME_PACER_IRQ_EN to add the ports frame_irq (out), a
// registered one-cycle pulse per tick, and irq_mask (in), which forces frame_irq to 0.
module frame_pacer_ci #(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned DEFAULT_PERIOD = 833334,
  parameter int unsigned OVR_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
`ifdef FRAME_PACER_IRQ_EN
  input  logic        irq_mask,
  output logic        frame_irq,
`endif
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StDelay, StWait, StFin} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [OVR_W-1:0] pending_q, pending_d;
  logic [31:0]      frame_count_q, frame_count_d;
  logic [31:0]      result_q, result_d;
  logic             done_q, done_d;

  logic             tick;
  logic [CNT_W-1:0] arg_a;
  logic [CNT_W-1:0] delay_tgt;
  logic [CNT_W-1:0] new_period;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_bits;

  assign arg_a      = dataa[CNT_W-1:0];
  assign tick       = (timer_q == period_q - CNT_W'(1));
  assign delay_tgt  = (arg_a == '0) ? period_q : arg_a;
  assign new_period = (arg_a < CNT_W'(2)) ? CNT_W'(2) : arg_a;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // Operand bits that no opcode uses.
  assign unused_bits = ^{dataa[31:CNT_W], datab[31:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    result_d = result_q;
    done_d   = done_q;
    period_d = period_q;

    // Timer and frame bookkeeping run regardless of clk_en. The opcodes below may
    // override these defaults.
    timer_d       = tick ? '0 : timer_q + CNT_W'(1);
    frame_count_d = tick ? frame_count_q + 32'd1 : frame_count_q;
    pending_d     = (tick && (pending_q != '1)) ? pending_q + OVR_W'(1) : pending_q;

    if (clk_en) begin
      unique case (state_q)
        StIdle: begin
          done_d = 1'b0;
          if (start) begin
            unique case (n)
              2'd0: begin
                target_d = delay_tgt;
                cnt_d    = '0;
                // The issue cycle is the first delay cycle, so a target of 1
                // completes straight away.
                if (delay_tgt == CNT_W'(1)) begin
                  result_d = '0;
                  state_d  = StFin;
                end else begin
                  state_d = StDelay;
                end
              end
              2'd1: begin
                period_d  = new_period;
                timer_d   = '0;
                pending_d = '0;
                result_d  = 32'(period_q);
                state_d   = StFin;
              end
              2'd2: begin
                if (pending_q != '0) begin
                  result_d  = 32'(pending_q);
                  // A tick in this same cycle is a new missed frame.
                  pending_d = tick ? OVR_W'(1) : '0;
                  state_d   = StFin;
                end else begin
                  state_d = StWait;
                end
              end
              2'd3: begin
                result_d = frame_count_q;
                if (datab[0]) begin
                  frame_count_d = tick ? 32'd1 : 32'd0;
                end
                state_d = StFin;
              end
            endcase
          end
        end
        StDelay: begin
          cnt_d = cnt_inc;
          if (cnt_inc == target_q - CNT_W'(1)) begin
            result_d = '0;
            state_d  = StFin;
          end
        end
        StWait: begin
          if (tick) begin
            result_d  = '0;
            pending_d = '0;  // this tick is the frame we waited for
            state_d   = StFin;
          end
        end
        StFin: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      period_q      <= CNT_W'(DEFAULT_PERIOD);
      timer_q       <= '0;
      cnt_q         <= '0;
      target_q      <= '0;
      pending_q     <= '0;
      frame_count_q <= '0;
      result_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      timer_q       <= timer_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      pending_q     <= pending_d;
      frame_count_q <= frame_count_d;
      result_q      <= result_d;
      done_q        <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

`ifdef FRAME_PACER_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = tick & ~irq_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign frame_irq = irq_q;
`endif

endmodule
